// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among NREQ valid/ready requesters, one op in flight.
// Optional macro ALU_SCHED_DIVZ_TRAP_EN: div/mod by zero answered locally with rsp_err.
module alu_sched #(
    parameter int DW      = 18,
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_datA,
    input  logic [NREQ*DW-1:0]   req_datB,
    input  logic [NREQ*4-1:0]    req_ctrl,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DW:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic [DW-1:0]        alu_datA,
    output logic [DW-1:0]        alu_datB,
    output logic [3:0]           alu_ctrl,
    input  logic [DW:0]          alu_result,
    input  logic                 alu_ovf,
    input  logic                 alu_AgtB,
    input  logic                 alu_N,
    input  logic                 alu_Z
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [IW-1:0] rr_ptr, gnt_q, gnt_sel;
    logic          gnt_found;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] sel_datA, sel_datB;
    logic [3:0]    sel_ctrl;
    logic          accept, divz;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[wrap_add(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_sel   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign sel_datA = req_datA[int'(gnt_sel)*DW +: DW];
    assign sel_datB = req_datB[int'(gnt_sel)*DW +: DW];
    assign sel_ctrl = req_ctrl[int'(gnt_sel)*4 +: 4];
    assign accept   = (state == IDLE) && gnt_found;

`ifdef ALU_SCHED_DIVZ_TRAP_EN
    assign divz = ((sel_ctrl[2:0] == 3'd3) || (sel_ctrl[2:0] == 3'd4)) && (sel_datB == '0);
`else
    assign divz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[gnt_sel] = 1'b1;
                    state_nxt          = divz ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (wait_cnt == '0) state_nxt = RESP;
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU inputs only change on an issued accept, so they hold steady while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            gnt_q      <= '0;
            wait_cnt   <= '0;
            alu_datA   <= '0;
            alu_datB   <= '0;
            alu_ctrl   <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                gnt_q  <= gnt_sel;
                rr_ptr <= wrap_add(gnt_sel, 1);
                if (divz) begin
                    rsp_result <= '0;
                    rsp_flags  <= 4'b0001;
                end else begin
                    alu_datA <= sel_datA;
                    alu_datB <= sel_datB;
                    alu_ctrl <= sel_ctrl;
                end
            end
            case (state)
                ISSUE: wait_cnt <= CW'(ALU_LAT - 1);
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_flags  <= {alu_ovf, alu_AgtB, alu_N, alu_Z};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SCHED_DIVZ_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)         rsp_err <= 1'b0;
        else if (accept) rsp_err <= divz;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: behavioural ALU, directed table, corner sequences, random model.
module tb_alu_sched;
    localparam int DW = 18, NREQ = 2, LAT = 1;

    logic clk = 1'b0, rst;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0] req_datA, req_datB;
    logic [NREQ*4-1:0] req_ctrl;
    logic [DW:0] rsp_result, alu_result;
    logic [3:0] rsp_flags, alu_ctrl;
    logic rsp_err, alu_ovf, alu_AgtB, alu_N, alu_Z;
    logic [DW-1:0] alu_datA, alu_datB;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_sched #(.DW(DW), .NREQ(NREQ), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_datA(req_datA), .req_datB(req_datB), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .alu_datA(alu_datA),
        .alu_datB(alu_datB), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .alu_ovf(alu_ovf), .alu_AgtB(alu_AgtB), .alu_N(alu_N), .alu_Z(alu_Z));

    // ALU behaviour: {ovf, AgtB, N, Z, result}; ctrl[3] doubles the result.
    function automatic logic [DW+4:0] alu_fn(input logic [DW-1:0] a, b, input logic [3:0] c);
        logic [DW:0] r;
        case (c[2:0])
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {1'b0, a} - {1'b0, b};
            3'd2: r = {1'b0, a & b};
            3'd3: r = (b == '0) ? '0 : {1'b0, a / b};
            3'd4: r = (b == '0) ? '0 : {1'b0, a % b};
            3'd5: r = {1'b0, a | b};
            3'd6: r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        if (c[3]) r = r << 1;
        return {r[DW] ^ r[DW-1], a > b, r[DW], r == '0, r};
    endfunction

    logic [DW+4:0] alu_pipe [LAT];
    initial for (int s = 0; s < LAT; s++) alu_pipe[s] = '0;
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_datA, alu_datB, alu_ctrl);
        for (int s = 1; s < LAT; s++) alu_pipe[s] <= alu_pipe[s-1];
    end
    assign {alu_ovf, alu_AgtB, alu_N, alu_Z, alu_result} = alu_pipe[LAT-1];

    // Scheduler-visible expectation for one request.
    task automatic expect_of(input logic [DW-1:0] a, b, input logic [3:0] c,
                             output logic [DW:0] res, output logic [3:0] flg,
                             output logic err, output int lat);
        {flg, res} = alu_fn(a, b, c);
        err = 1'b0;
        lat = LAT + 2;
`ifdef ALU_SCHED_DIVZ_TRAP_EN
        if ((c[2:0] == 3'd3 || c[2:0] == 3'd4) && b == '0) begin
            res = '0; flg = 4'b0001; err = 1'b1; lat = 1;
        end
`endif
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, b, input logic [3:0] c);
        req_datA[i*DW +: DW] = a;
        req_datB[i*DW +: DW] = b;
        req_ctrl[i*4 +: 4]   = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for any grant, then for the response; completes the handshake.
    task automatic serve(output logic [NREQ-1:0] g, rv, output logic [DW:0] res,
                         output logic [3:0] flg, output int lat);
        int w = 0;
        #1;
        while (req_ready == '0 && w < 20) begin @(negedge clk); #1; w++; end
        if (w >= 20) check("grant_timeout", 0, 1);
        g = req_ready;
        @(negedge clk);
        lat = 1;
        while (rsp_valid == '0 && lat < 20) begin @(negedge clk); lat++; end
        rv = rsp_valid; res = rsp_result; flg = rsp_flags;
        rsp_ready = rv;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic run_one(input int r, input logic [DW-1:0] a, b, input logic [3:0] c,
                           output logic [DW:0] res, output logic [3:0] flg,
                           output logic err, output int lat);
        int w = 0;
        set_req(r, a, b, c);
        req_valid[r] = 1'b1;
        #1;
        while (!req_ready[r] && w < 20) begin @(negedge clk); #1; w++; end
        if (w >= 20) check("accept_timeout", 0, 1);
        @(negedge clk);
        req_valid[r] = 1'b0;
        lat = 1;
        while (!rsp_valid[r] && lat < 20) begin @(negedge clk); lat++; end
        res = rsp_result; flg = rsp_flags; err = rsp_err;
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
    endtask

    typedef struct {
        int r; logic [DW-1:0] a, b; logic [3:0] c;
        logic [DW:0] res; logic [3:0] flg; logic err; int lat;
    } vec_t;
    vec_t tbl [13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] g, rv, exp_rdy, exp_rv;
        logic [DW:0] res, e_res;
        logic [3:0] flg, e_flg;
        logic err, e_err;
        int lat, e_lat, e_idx, ptr, cnt, done, drop_g, gi;
        bit busy;
        logic [DW-1:0] pa [NREQ], pb [NREQ];
        logic [3:0] pc [NREQ];
        logic [NREQ-1:0] exp_g [3];

        tbl[0]  = '{0, 18'd5,      18'd7,      4'd0, 19'd12,     4'b0000, 1'b0, LAT+2};
        tbl[1]  = '{1, 18'd3,      18'd3,      4'd1, 19'd0,      4'b0001, 1'b0, LAT+2};
        tbl[2]  = '{0, 18'd9,      18'd2,      4'd2, 19'd0,      4'b0101, 1'b0, LAT+2};
        tbl[3]  = '{1, 18'd3,      18'd4,      4'd8, 19'd14,     4'b0000, 1'b0, LAT+2};
        tbl[4]  = '{0, 18'd100,    18'd7,      4'd3, 19'd14,     4'b0100, 1'b0, LAT+2};
        tbl[5]  = '{1, 18'd100,    18'd7,      4'd4, 19'd2,      4'b0100, 1'b0, LAT+2};
        tbl[6]  = '{0, 18'd0,      18'd1,      4'd1, 19'h7FFFF,  4'b0010, 1'b0, LAT+2};
        tbl[7]  = '{1, 18'h20000,  18'h20000,  4'd0, 19'h40000,  4'b1010, 1'b0, LAT+2};
        tbl[8]  = '{0, 18'd5,      18'd5,      4'd7, 19'd0,      4'b0001, 1'b0, LAT+2};
`ifdef ALU_SCHED_DIVZ_TRAP_EN
        tbl[9]  = '{1, 18'd9,      18'd0,      4'd3, 19'd0,      4'b0001, 1'b1, 1};
`else
        tbl[9]  = '{1, 18'd9,      18'd0,      4'd3, 19'd0,      4'b0101, 1'b0, LAT+2};
`endif
        tbl[10] = '{0, 18'd12,     18'd3,      4'd5, 19'd15,     4'b0100, 1'b0, LAT+2};
        tbl[11] = '{1, 18'd6,      18'd6,      4'd6, 19'd0,      4'b0001, 1'b0, LAT+2};
        tbl[12] = '{0, 18'd10,     18'd3,      4'd9, 19'd14,     4'b0100, 1'b0, LAT+2};

        req_valid = '0; rsp_ready = '0; req_datA = '0; req_datB = '0; req_ctrl = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rsp", {req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err}, 0);
        check("rst_alu", {alu_datA, alu_datB, alu_ctrl}, 0);
        rst = 1'b0;

        // Single add from reset
        run_one(0, 18'd5, 18'd7, 4'd0, res, flg, err, lat);
        check("t1_result", res, 12);
        check("t1_flags", flg, 4'b0000);
        check("t1_latency", lat, LAT + 2);

        // Simultaneous requesters rotate 0,1,0
        do_reset();
        set_req(0, 18'd1, 18'd2, 4'd0);
        set_req(1, 18'd10, 18'd20, 4'd0);
        req_valid = 2'b11;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            serve(g, rv, res, flg, lat);
            check($sformatf("t2_grant%0d", k), g, exp_g[k]);
            check($sformatf("t2_rspv%0d", k), rv, exp_g[k]);
            check($sformatf("t2_result%0d", k), res, exp_g[k][1] ? 19'd30 : 19'd3);
        end
        req_valid = '0;

        // Response backpressure holds result and blocks new grants
        set_req(1, 18'd3, 18'd3, 4'd1);
        req_valid = 2'b10;
        #1 check("t3_grant", req_ready, 2'b10);
        @(negedge clk);
        set_req(0, 18'd2, 18'd2, 4'd0);
        req_valid = 2'b01;
        repeat (LAT + 1) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            rsp_ready = 2'b01;
            #1;
            check($sformatf("t3_hold_v%0d", k), rsp_valid, 2'b10);
            check($sformatf("t3_hold_r%0d", k), {rsp_result, rsp_flags}, {19'd0, 4'b0001});
            check($sformatf("t3_blocked%0d", k), req_ready, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = '0;
        #1 check("t3_next_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (rsp_valid == '0 && lat < 20) begin @(negedge clk); lat++; end
        check("t3_req0_rsp", {rsp_valid, rsp_result}, {2'b01, 19'd4});
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;

        // Reset during WAIT drops the transaction and the rotation pointer
        set_req(0, 18'd5, 18'd6, 4'd0);
        req_valid = 2'b01;
        #1 check("t4_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("t4_after_rst", {rsp_valid, req_ready, rsp_result}, 0);
        check("t4_alu_cleared", {alu_datA, alu_datB, alu_ctrl}, 0);
        repeat (3) begin
            @(negedge clk);
            check("t4_no_rsp", rsp_valid, 0);
        end
        set_req(1, 18'd1, 18'd1, 4'd0);
        req_valid = 2'b11;
        #1 check("t4_ptr_reset", req_ready, 2'b01);
        serve(g, rv, res, flg, lat);
        req_valid = '0;
        check("t4_rsp", {rv, res}, {2'b01, 19'd11});

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_one(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, res, flg, err, lat);
            check($sformatf("vec%0d_result", i), res, tbl[i].res);
            check($sformatf("vec%0d_flags", i), flg, tbl[i].flg);
            check($sformatf("vec%0d_err", i), err, tbl[i].err);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // Random traffic vs. a transaction-level model
        do_reset();
        busy = 0; ptr = 0; cnt = 0; done = 0; drop_g = -1; e_idx = 0;
        e_res = '0; e_flg = '0; e_err = 1'b0; e_lat = 0;
        for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; pc[i] = '0; end
        for (int cyc = 0; cyc < 6000 && done < 300; cyc++) begin
            @(negedge clk);
            if (drop_g >= 0) begin req_valid[drop_g] = 1'b0; drop_g = -1; end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    pa[i] = DW'($urandom);
                    pb[i] = ($urandom_range(3) == 0) ? '0 : DW'($urandom >> $urandom_range(DW));
                    pc[i] = 4'($urandom_range(15));
                    set_req(i, pa[i], pb[i], pc[i]);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = NREQ'($urandom);
            #1;
            exp_rdy = '0; gi = -1;
            if (!busy) begin
                for (int k = 0; k < NREQ; k++)
                    if (gi < 0 && req_valid[(ptr + k) % NREQ]) gi = (ptr + k) % NREQ;
                if (gi >= 0) exp_rdy[gi] = 1'b1;
            end
            check("rnd_ready", req_ready, exp_rdy);
            exp_rv = '0;
            if (busy && cnt >= e_lat) exp_rv[e_idx] = 1'b1;
            check("rnd_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != '0) check("rnd_rsp_data", {rsp_err, rsp_flags, rsp_result}, {e_err, e_flg, e_res});
            if (busy) begin
                if (exp_rv != '0 && rsp_ready[e_idx]) begin busy = 0; done++; end
                else cnt++;
            end else if (gi >= 0) begin
                busy = 1; cnt = 1; e_idx = gi; drop_g = gi;
                expect_of(pa[gi], pb[gi], pc[gi], e_res, e_flg, e_err, e_lat);
                ptr = (gi + 1) % NREQ;
            end
        end
        check("rnd_progress", done, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
